// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the insertion-sort array sequencer.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    FLUSH
  } sort_state_t;

  function automatic int unsigned count_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned NUM_CELLS_DEF = 16;
  localparam int unsigned COUNT_W       = count_w(NUM_CELLS_DEF);

endpackage

// File: rtl/sort_controller.sv
// Sequencer for an insertion-sort cell chain: loads one word per cycle, drains
// the chain in ascending order, then pulses array_clear for one cycle.
module sort_controller
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CELLS  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  input  logic [DATA_WIDTH-1:0]             head_data,
  output logic                              cell_enable,
  output logic                              cell_shift_up,
  output logic [DATA_WIDTH-1:0]             cell_new_data,
  output logic                              array_clear,
  output logic                              busy,
  output logic [count_w(NUM_CELLS)-1:0]     count
);

  localparam int unsigned CW = count_w(NUM_CELLS);
  localparam logic [CW-1:0] FULL      = CW'(NUM_CELLS);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_CELLS - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  sort_state_t   state_q;
  logic [CW-1:0] count_q;
  logic          clear_q;
  logic          accept;
  logic          pop;

  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    cell_enable   = 1'b0;
    cell_shift_up = 1'b0;
    // All-ones never displaces an occupied cell, so it is a safe idle value.
    cell_new_data = '1;
    accept        = 1'b0;
    pop           = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = (count_q < FULL);
        accept   = in_valid && in_ready;
        if (accept) begin
          cell_enable   = 1'b1;
          cell_new_data = in_data;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (count_q == ONE);
        pop       = out_ready;
        if (pop) begin
          cell_enable   = 1'b1;
          cell_shift_up = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      count_q <= '0;
      clear_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            count_q <= count_q + ONE;
            if (in_last || (count_q == LAST_SLOT)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            count_q <= count_q - ONE;
            if (count_q == ONE) begin
              state_q <= FLUSH;
              clear_q <= 1'b1;
            end
          end
        end
        FLUSH:   state_q <= LOAD;
        default: state_q <= LOAD;
      endcase
    end
  end

  assign out_data    = head_data;
  assign array_clear = clear_q;
  assign count       = count_q;
  assign busy        = (state_q != LOAD) || (count_q != '0);

endmodule

// File: tb/tb_sort_controller.sv
// Scoreboard bench for sort_controller with a behavioural sorted-array model
// standing in for the cell chain.
module tb_sort_controller;

  localparam int DW = 8;
  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [DW-1:0] head_data = '0;
  logic          cell_enable;
  logic          cell_shift_up;
  logic [DW-1:0] cell_new_data;
  logic          array_clear;
  logic          busy;
  logic [4:0]    count;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];
  logic [7:0] arr[$];
  int exp_cnt;

  always #5 clk = ~clk;

  sort_controller #(.DATA_WIDTH(DW), .NUM_CELLS(NC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .head_data(head_data), .cell_enable(cell_enable), .cell_shift_up(cell_shift_up),
    .cell_new_data(cell_new_data), .array_clear(array_clear), .busy(busy), .count(count)
  );

  always @(posedge clk or posedge reset) begin
    int idx;
    if (reset || array_clear) begin
      arr.delete();
    end else if (cell_enable && cell_shift_up) begin
      if (arr.size() > 0) void'(arr.pop_front());
    end else if (cell_enable) begin
      idx = 0;
      while (idx < arr.size() && arr[idx] <= cell_new_data) idx++;
      arr.insert(idx, cell_new_data);
    end
    head_data = (arr.size() > 0) ? arr[0] : 8'h00;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        if (out_ready) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0d expected none", out_data);
        end
      end else if (out_ready) begin
        e = sb.pop_front();
        chk("out_data", out_data, e[7:0]);
        chk("out_last", out_last, e[8]);
      end else begin
        e = sb[0];
        chk("stall_data", out_data, e[7:0]);
        chk("stall_last", out_last, e[8]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w, input logic last);
    sb.push_back({last, w});
  endtask

  task automatic send(input logic [7:0] w, input logic last);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    @(negedge clk);
    chk("in_ready", in_ready, 1);
    chk("acc_enable", cell_enable, 1);
    chk("acc_shift", cell_shift_up, 0);
    chk("acc_new_data", cell_new_data, w);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_clear", array_clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_enable", cell_enable, 0);
    chk("rst_shift", cell_shift_up, 0);
    chk("rst_new_data", cell_new_data, 255);
    @(posedge clk);
    #1 reset = 1'b0;

    // Frame 5,3,9,1
    out_ready = 1'b1;
    push(1, 0); push(3, 0); push(5, 0); push(9, 1);
    send(5, 0); send(3, 0); send(9, 0); send(1, 1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_count", count, 4);
    chk("t1_in_ready_drain", in_ready, 0);
    repeat (4) tick();
    chk("t1_flush_clear", array_clear, 1);
    chk("t1_flush_out_valid", out_valid, 0);
    chk("t1_flush_in_ready", in_ready, 0);
    chk("t1_flush_busy", busy, 1);
    tick();
    chk("t1_load_in_ready", in_ready, 1);
    chk("t1_load_clear", array_clear, 0);
    chk("t1_load_count", count, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // 16 words, implicit last
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(255 - i), 0);
    for (int i = 0; i < 16; i++) push(8'(240 + i), (i == 15));
    chk("t2_full_in_ready", in_ready, 0);
    chk("t2_full_count", count, 16);
    chk("t2_out_valid", out_valid, 1);
    tick();
    chk("t2_hold_count", count, 16);
    out_ready = 1'b1;
    wait_idle();
    chk("t2_sb_empty", sb.size(), 0);

    // Frame 7,7,2,7 with out_ready toggling
    out_ready = 1'b0;
    push(2, 0); push(7, 0); push(7, 0); push(7, 1);
    send(7, 0); send(7, 0); send(2, 0); send(7, 1);
    exp_cnt = 4;
    for (int c = 0; c < 20 && exp_cnt > 0; c++) begin
      @(negedge clk);
      chk("t3_count", count, exp_cnt);
      if (out_ready) exp_cnt--;
      tick();
      out_ready = ~out_ready;
    end
    chk("t3_flush_clear", array_clear, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_load_in_ready", in_ready, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // Single word 42
    push(42, 1);
    send(42, 1);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_out_last", out_last, 1);
    chk("t4_count", count, 1);
    tick();
    chk("t4_flush_clear", array_clear, 1);
    chk("t4_flush_busy", busy, 1);
    tick();
    chk("t4_in_ready", in_ready, 1);
    chk("t4_busy", busy, 0);

    // Reset mid-drain
    push(2, 0); push(4, 0); push(6, 0); push(8, 1);
    send(6, 0); send(2, 0); send(8, 0); send(4, 1);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_count", count, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_clear", array_clear, 0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    push(4, 0); push(8, 1);
    send(8, 0); send(4, 1);
    wait_idle();
    chk("t5_sb_empty", sb.size(), 0);

    // Back-to-back frames
    push(1, 0); push(3, 1);
    send(3, 0); send(1, 1);
    wait_idle();
    push(0, 0); push(2, 0); push(6, 1);
    send(6, 0); send(0, 0); send(2, 1);
    wait_idle();
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_controller.md
# sort_controller

Sequencer for a linear chain of `NUM_CELLS` sorting cells that together form an insertion-sort array. It accepts a frame of unsorted words over a valid/ready stream and inserts one word per cycle. It then drains the array in ascending order over a second valid/ready stream and clears the array for the next frame. It sits between the upstream data source and the cell chain, and drives the chain's shared `enable`, `shift_up` and `new_data` lines and its reset.

## Interface
- `DATA_WIDTH`, 8, width of sorted words
- `NUM_CELLS`, 16, number of cells in the chain (≥2); maximum frame length
- `clk` input 1 — single clock
- `reset` input 1 — asynchronous, active-high
- `in_valid` input 1 — upstream word valid
- `in_ready` output 1 — controller accepts word this cycle
- `in_data` input DATA_WIDTH — unsorted word
- `in_last` input 1 — final word of frame
- `out_valid` output 1 — sorted word available
- `out_ready` input 1 — downstream accepts word
- `out_data` output DATA_WIDTH — sorted word; equals `head_data`
- `out_last` output 1 — final sorted word of frame
- `head_data` input DATA_WIDTH — cell 0 data (smallest stored value)
- `cell_enable` output 1 — shared cell enable
- `cell_shift_up` output 1 — shared shift toward cell 0
- `cell_new_data` output DATA_WIDTH — shared insertion word
- `array_clear` output 1 — ORed into the cell chain's async reset
- `busy` output 1 — state ≠ LOAD or `count` ≠ 0
- `count` output $clog2(NUM_CELLS+1) — words currently stored

## Operation
- States: LOAD, DRAIN, FLUSH. Reset state is LOAD with `count`=0.
- **LOAD**
  - `in_ready` = (`count` < NUM_CELLS).
  - On accept (`in_valid`&`in_ready`): `cell_enable`=1, `cell_new_data`=`in_data`, `cell_shift_up`=0, `count`+1.
  - Goes to DRAIN after accepting `in_last`, or after accepting the NUM_CELLS-th word (implicit last).
- **DRAIN**
  - `out_valid`=1; `out_data`=`head_data`; `out_last`=(`count`==1); `in_ready`=0.
  - On pop (`out_valid`&`out_ready`): `cell_enable`=1, `cell_shift_up`=1, `count`−1.
  - A pop with `count`==1 goes to FLUSH.
- **FLUSH**
  - `array_clear`=1 for exactly one cycle; all handshakes deasserted.
  - Returns to LOAD.
- Outside LOAD accepts, `cell_new_data` is driven to all-ones. A word equal to the maximum value never displaces an occupied cell, so no insertion push can coincide with a shift.
- Outside accepts and pops, `cell_enable`=0 and `cell_shift_up`=0.
- Duplicate values are permitted and their order is not defined.
- `count` never exceeds NUM_CELLS and never underflows.
- There is no zero-length frame: a frame begins with its first accepted word.

## Timing
- `array_clear` and `count` are registered, and so is the state.
- All other outputs are combinational decodes of state, `count` and the handshakes.
- Reset values (reset asserted): state LOAD, `count`=0, `array_clear`=0, `busy`=0, `in_ready`=1, `out_valid`=0, `out_last`=0, `cell_enable`=0, `cell_shift_up`=0, `cell_new_data`=all-ones; `out_data` follows `head_data`.
- Insertion latency: a word accepted in cycle N is resident in the array at N+1.
- First `out_valid` is the cycle after the final accept. Sustained throughput is one word per cycle in each direction.
- Frame of K words: K load cycles + K drain cycles (with `out_ready` held high) + 1 FLUSH cycle. LOAD is then re-entered with `in_ready`=1.
- `out_ready` low holds `out_data`, `out_last` and `count` stable.
- Reset mid-frame: returns to LOAD and `count`=0 immediately. The array is cleared through the shared `reset`, and no partial frame is emitted.

## Structure
- Package `sort_pkg` contains:
  - `sort_state_t` enum {LOAD, DRAIN, FLUSH}
  - `COUNT_W` = $clog2(NUM_CELLS+1) helper
- The controller has no sub-modules. A separate top, `sort_unit`, instantiates `sort_controller` and a `sorting_array` chain of `NUM_CELLS` cells.
  - Last cell `next_cell_data`=0; first cell `prev_cell_state`=1.
  - Array reset = `reset` | `array_clear`.

## Test plan
- Frame 5,3,9,1 (last on 1), `out_ready` high → outputs 1,3,5,9 on consecutive cycles; `out_last` only with 9; one FLUSH cycle; `in_ready`=1 next cycle.
- 16 words 255 down to 240 with no `in_last` → `in_ready`=0 after 16th word; drain emits 240..255; `out_last` on 255.
- Frame 7,7,2,7 with `out_ready` toggling every cycle → 2,7,7,7; outputs stable while stalled; `count` steps 4→0 only on pops.
- Single word 42 with `in_last` → DRAIN next cycle, 42 with `out_last`=1; then FLUSH, then LOAD.
- `reset` asserted after two of four drained words → `out_valid`=0, `count`=0 and `in_ready`=1 immediately. The next frame 8,4 with `in_last` on 4 emits 4,8 only.
- Back-to-back frames {3,1} then {6,0,2} → second frame emits 0,2,6 with no residue from the first.
